uart_rx: RTL and testbench

- Serial receive stage of the UART; the receive-side counterpart to the transmitter.
- Samples the external i_rx line using a 16x-baud tick strobe from the clock generator and deserialises frames LSB first.
- Each frame is 1 start bit, WIDTH_DATA data bits and NB_STOP stop bits, no parity.
- Presents each received word in a single holding register with a ready/read-enable handshake to the in-chip side.
- Flags framing and overrun errors.

---
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, LSB-first deserialiser with a single
// holding register, ready/read-enable handshake and sticky error flags.
module uart_rx #(
    parameter int WIDTH_DATA = 8,
    parameter int NB_STOP    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    input  logic                  i_tick,
    input  logic                  i_re,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic                  o_rdy,
    output logic                  o_ferr,
    output logic                  o_ovr,
    output logic                  o_busy
);
    localparam int BW = (WIDTH_DATA > 2) ? $clog2(WIDTH_DATA) : 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH_DATA - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(NB_STOP - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_n;
    logic                  rx_meta, rxs;
    logic [3:0]            tick_cnt, tick_n;
    logic [BW-1:0]         bit_cnt, bit_n;
    logic [WIDTH_DATA-1:0] shreg, shreg_n;
    logic                  frame_bad, frame_bad_n;
    logic                  stop_bad, done_good, done_bad;
    logic                  overrun, load;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_bad <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shreg     <= shreg_n;
            frame_bad <= frame_bad_n;
        end
    end

    always_comb begin
        state_n     = state;
        tick_n      = tick_cnt;
        bit_n       = bit_cnt;
        shreg_n     = shreg;
        frame_bad_n = frame_bad;
        done_good   = 1'b0;
        done_bad    = 1'b0;
        stop_bad    = frame_bad | ~rxs;
        case (state)
            IDLE: begin
                if (i_tick && !rxs) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_cnt == 4'd7) begin
                        if (!rxs) begin
                            state_n = DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shreg_n = {rxs, shreg[WIDTH_DATA-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            state_n     = STOP;
                            tick_n      = '0;
                            bit_n       = '0;
                            frame_bad_n = 1'b0;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a start edge right after it is not missed.
                if (i_tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (bit_cnt == LAST_STOP) begin
                            state_n   = IDLE;
                            done_good = ~stop_bad;
                            done_bad  = stop_bad;
                        end else begin
                            bit_n       = bit_cnt + 1'b1;
                            frame_bad_n = stop_bad;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign overrun = done_good & o_rdy & ~i_re;
    assign load    = done_good & ~overrun;
    assign o_busy  = (state != IDLE);

    // Flag set beats the read-enable clear; a load beats the o_rdy clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data <= '0;
            o_rdy  <= 1'b0;
            o_ferr <= 1'b0;
            o_ovr  <= 1'b0;
        end else begin
            if (load) begin
                o_data <= shreg;
                o_rdy  <= 1'b1;
            end else if (i_re) begin
                o_rdy <= 1'b0;
            end
            if (done_bad)  o_ferr <= 1'b1;
            else if (i_re) o_ferr <= 1'b0;
            if (overrun)   o_ovr  <= 1'b1;
            else if (i_re) o_ovr  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected output-state changes are queued by
// the stimulus and consumed by a monitor whenever the DUT outputs change.
module tb_uart_rx;
    typedef struct packed {
        logic [7:0] data;
        logic       rdy;
        logic       ferr;
        logic       ovr;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx1 = 1'b1, re1 = 1'b0;
    logic       rx2 = 1'b1, re2 = 1'b0;
    logic [7:0] data1;
    logic       rdy1, ferr1, ovr1, busy1;
    logic [6:0] data2;
    logic       rdy2, ferr2, ovr2, busy2;

    int   checks = 0;
    int   passes = 0;
    logic sel = 1'b0;
    obs_t exp_q[$];

    uart_rx #(.WIDTH_DATA(8), .NB_STOP(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_rx(rx1), .i_tick(tick), .i_re(re1),
        .o_data(data1), .o_rdy(rdy1), .o_ferr(ferr1), .o_ovr(ovr1), .o_busy(busy1)
    );

    uart_rx #(.WIDTH_DATA(7), .NB_STOP(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_rx(rx2), .i_tick(tick), .i_re(re2),
        .o_data(data2), .o_rdy(rdy2), .o_ferr(ferr2), .o_ovr(ovr2), .o_busy(busy2)
    );

    initial forever #5 clk = ~clk;

    // Tick every 4 clocks, updated just after the edge.
    initial begin
        int tdiv;
        tdiv = 0;
        forever begin
            @(posedge clk);
            #1;
            tdiv = (tdiv + 1) % 4;
            tick = (tdiv == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Monitor: every change of dut1's visible state must match the next queued entry.
    initial begin
        obs_t cur, prev, e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {data1, rdy1, ferr1, ovr1};
            if (rst) begin
                prev = cur;
            end else if (cur != prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got data=%h rdy=%b ferr=%b ovr=%b, required no change",
                             cur.data, cur.rdy, cur.ferr, cur.ovr);
                end else begin
                    e = exp_q.pop_front();
                    if (e == cur) passes++;
                    else $display("FAIL sb_event: got data=%h rdy=%b ferr=%b ovr=%b, required data=%h rdy=%b ferr=%b ovr=%b",
                                  cur.data, cur.rdy, cur.ferr, cur.ovr, e.data, e.rdy, e.ferr, e.ovr);
                end
                prev = cur;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic push(input logic [7:0] d, input logic r, input logic f, input logic o);
        exp_q.push_back({d, r, f, o});
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input logic b);
        if (sel == 1'b0) rx1 = b;
        else rx2 = b;
    endtask

    task automatic set_re(input logic b);
        if (sel == 1'b0) re1 = b;
        else re2 = b;
    endtask

    task automatic pulse_re();
        set_re(1'b1);
        @(posedge clk);
        #1;
        set_re(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ticks(2);
    endtask

    // Frame completes on the 9th tick of the last stop bit; re_at_done
    // places i_re exactly in that cycle.
    task automatic send(input logic [7:0] d, input int nbits, input logic [1:0] stops,
                        input int nstop, input bit re_at_done);
        wait_ticks(1);
        drive(1'b0);
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            drive(d[i]);
            wait_ticks(16);
        end
        for (int s = 0; s < nstop; s++) begin
            drive(stops[s]);
            if (re_at_done && s == nstop - 1) begin
                wait_ticks(8);
                repeat (3) @(posedge clk);
                #1;
                set_re(1'b1);
                @(posedge clk);
                #1;
                set_re(1'b0);
                wait_ticks(7);
            end else begin
                wait_ticks(16);
            end
        end
        drive(1'b1);
        wait_ticks(16);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(data1), 32'h0);
        check("reset_rdy", 32'(rdy1), 32'h0);
        check("reset_ferr", 32'(ferr1), 32'h0);
        check("reset_ovr", 32'(ovr1), 32'h0);
        check("reset_busy", 32'(busy1), 32'h0);
        rst = 1'b0;
        wait_ticks(4);

        sel = 1'b0;
        push(8'hA5, 1'b1, 1'b0, 1'b0);
        send(8'hA5, 8, 2'b11, 1, 1'b0);
        check("a5_busy_idle", 32'(busy1), 32'h0);
        push(8'hA5, 1'b0, 1'b0, 1'b0);
        pulse_re();
        wait_ticks(2);

        wait_ticks(1);
        drive(1'b0);
        wait_ticks(4);
        drive(1'b1);
        wait_ticks(2);
        check("glitch_busy_mid", 32'(busy1), 32'h1);
        wait_ticks(6);
        check("glitch_busy_end", 32'(busy1), 32'h0);
        check("glitch_rdy", 32'(rdy1), 32'h0);
        check("glitch_ferr", 32'(ferr1), 32'h0);
        wait_ticks(8);

        do_reset();
        push(8'h00, 1'b0, 1'b1, 1'b0);
        send(8'h3C, 8, 2'b10, 1, 1'b0);
        push(8'h00, 1'b0, 1'b0, 1'b0);
        pulse_re();
        wait_ticks(2);

        push(8'h11, 1'b1, 1'b0, 1'b0);
        send(8'h11, 8, 2'b11, 1, 1'b0);
        push(8'h11, 1'b1, 1'b0, 1'b1);
        send(8'h22, 8, 2'b11, 1, 1'b0);
        push(8'h33, 1'b1, 1'b0, 1'b0);
        send(8'h33, 8, 2'b11, 1, 1'b1);

        push(8'h33, 1'b0, 1'b1, 1'b0);
        send(8'h3C, 8, 2'b10, 1, 1'b1);
        push(8'h33, 1'b0, 1'b0, 1'b0);
        pulse_re();
        wait_ticks(2);

        wait_ticks(1);
        drive(1'b0);
        wait_ticks(16);
        drive(1'b1);
        wait_ticks(56);
        check("abort_busy_before", 32'(busy1), 32'h1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ticks(20);
        check("abort_busy", 32'(busy1), 32'h0);
        check("abort_data", 32'(data1), 32'h0);
        check("abort_flags", 32'({rdy1, ferr1, ovr1}), 32'h0);
        push(8'h5A, 1'b1, 1'b0, 1'b0);
        send(8'h5A, 8, 2'b11, 1, 1'b0);
        wait_ticks(4);

        sel = 1'b1;
        send(8'h55, 7, 2'b01, 2, 1'b0);
        check("ns2_bad_ferr", 32'(ferr2), 32'h1);
        check("ns2_bad_rdy", 32'(rdy2), 32'h0);
        check("ns2_bad_data", 32'(data2), 32'h0);
        pulse_re();
        check("ns2_ferr_clr", 32'(ferr2), 32'h0);
        send(8'h55, 7, 2'b11, 2, 1'b0);
        check("ns2_good_data", 32'(data2), 32'h55);
        check("ns2_good_rdy", 32'(rdy2), 32'h1);
        check("ns2_good_flags", 32'({ferr2, ovr2}), 32'h0);

        repeat (10) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
